// File: rtl/spi_pkg.sv
// Shared constants, FSM state encoding and helpers for the SPI loopback tester.
// Defaults describe the on-board 13-bit SPI pair.
package spi_pkg;

    localparam int          WIDTH_DEF   = 13;
    localparam logic [12:0] SEED_DEF    = 13'h1dad;
    localparam logic [12:0] TAPS_DEF    = 13'h100d;
    localparam int          TIMEOUT_DEF = 65535;
    localparam logic [15:0] CNT_MAX     = 16'hffff;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        CHECK   = 3'd4,
        ADVANCE = 3'd5
    } state_e;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR producing the master transmit pattern.
// An all-zero seed would lock up the register, so it is replaced by 1.
module lfsr_gen
    import spi_pkg::*;
#(
    parameter int               WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEF),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur);
        return {cur[WIDTH-2:0], ^(cur & TAPS)};
    endfunction

    // LFSR register: reload on reset/clear, shift once per step request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED_EFF;
        end else if (clr) begin
            q <= SEED_EFF;
        end else if (step) begin
            q <= lfsr_next(q);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/spi_loopback_tester.sv
// Traffic source and checker for the SPI master/slave loopback: launches frames,
// compares the received words against the sent pattern and keeps statistics.
module spi_loopback_tester
    import spi_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_DEF,
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(SEED_DEF),
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(TAPS_DEF),
    parameter int               TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic             ce,
    input  logic             load,
    input  logic [WIDTH-1:0] mrx_dat,
    input  logic [WIDTH-1:0] srx_dat,
    output logic             st,
    output logic [WIDTH-1:0] mtx_dat,
    output logic [WIDTH-1:0] stx_dat,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      fail_cnt,
    output logic             err,
    output logic             tmo,
    output logic             busy
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e          state_r;
    state_e          state_nxt_s;
    logic [TW-1:0]   wait_cnt_r;
    logic            st_r;
    logic            busy_r;
    logic [15:0]     pass_cnt_r;
    logic [15:0]     fail_cnt_r;
    logic            err_r;
    logic            tmo_r;

    logic            cnt_clr_s;
    logic            in_wait_s;
    logic            rec_pass_s;
    logic            rec_fail_s;
    logic            rec_tmo_s;
    logic            step_s;
    logic            match_s;
    logic            wait_expired_s;
    logic [WIDTH-1:0] lfsr_q_s;

    lfsr_gen #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .step  (step_s),
        .q     (lfsr_q_s)
    );

    assign mtx_dat  = lfsr_q_s;
    assign stx_dat  = ~lfsr_q_s;
    assign st       = st_r;
    assign busy     = busy_r;
    assign pass_cnt = pass_cnt_r;
    assign fail_cnt = fail_cnt_r;
    assign err      = err_r;
    assign tmo      = tmo_r;

    // Ideal loopback: each side receives exactly what the other side sent.
    assign match_s        = (mrx_dat == stx_dat) && (srx_dat == mtx_dat);
    assign wait_expired_s = (wait_cnt_r == TMO_LAST);

    // Next-state logic plus the one-cycle event strobes for counters and LFSR.
    always_comb begin
        state_nxt_s = state_r;
        cnt_clr_s   = 1'b0;
        in_wait_s   = 1'b0;
        rec_pass_s  = 1'b0;
        rec_fail_s  = 1'b0;
        rec_tmo_s   = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (ce && run) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                state_nxt_s = WAIT_LO;
                cnt_clr_s   = 1'b1;
            end
            WAIT_LO: begin
                in_wait_s = 1'b1;
                if (!load) begin
                    state_nxt_s = WAIT_HI;
                    cnt_clr_s   = 1'b1;
                end else if (wait_expired_s) begin
                    state_nxt_s = ADVANCE;
                    rec_fail_s  = 1'b1;
                    rec_tmo_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT_LO;
                end
            end
            WAIT_HI: begin
                in_wait_s = 1'b1;
                if (load) begin
                    state_nxt_s = CHECK;
                end else if (wait_expired_s) begin
                    state_nxt_s = ADVANCE;
                    rec_fail_s  = 1'b1;
                    rec_tmo_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT_HI;
                end
            end
            CHECK: begin
                state_nxt_s = ADVANCE;
                if (match_s) begin
                    rec_pass_s = 1'b1;
                end else begin
                    rec_fail_s = 1'b1;
                end
            end
            ADVANCE: begin
                state_nxt_s = IDLE;
                step_s      = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, start pulse, busy flag and the per-wait-state timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            st_r       <= 1'b0;
            busy_r     <= 1'b0;
            wait_cnt_r <= '0;
        end else if (clr) begin
            state_r    <= IDLE;
            st_r       <= 1'b0;
            busy_r     <= 1'b0;
            wait_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            st_r    <= (state_nxt_s == START);
            busy_r  <= (state_nxt_s != IDLE);
            if (cnt_clr_s) begin
                wait_cnt_r <= '0;
            end else if (in_wait_s) begin
                wait_cnt_r <= wait_cnt_r + TW'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Pass/fail statistics and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_r <= 16'd0;
            fail_cnt_r <= 16'd0;
            err_r      <= 1'b0;
            tmo_r      <= 1'b0;
        end else if (clr) begin
            pass_cnt_r <= 16'd0;
            fail_cnt_r <= 16'd0;
            err_r      <= 1'b0;
            tmo_r      <= 1'b0;
        end else begin
            if (rec_pass_s) begin
                pass_cnt_r <= sat_inc16(pass_cnt_r);
            end else begin
                pass_cnt_r <= pass_cnt_r;
            end
            if (rec_fail_s) begin
                fail_cnt_r <= sat_inc16(fail_cnt_r);
                err_r      <= 1'b1;
            end else begin
                fail_cnt_r <= fail_cnt_r;
                err_r      <= err_r;
            end
            if (rec_tmo_s) begin
                tmo_r <= 1'b1;
            end else begin
                tmo_r <= tmo_r;
            end
        end
    end

endmodule

// File: doc/spi_loopback_tester.md
# spi_loopback_tester

Self-checking traffic source and result checker for the on-board SPI master/slave loopback. Sits on both sides of the SPI pair:
- Upstream, it generates the master and slave transmit words plus the start strobe.
- Downstream, it consumes the received words and the frame-complete indication, compares them against what was sent, and keeps pass/fail statistics for the seven-segment display mux.

## Interface

Parameters:
- WIDTH, 13, SPI frame width in bits
- SEED, 13'h1dad, LFSR value after reset/clear; all-zero is replaced by 1
- TAPS, 13'h100d, Fibonacci feedback mask (x^13+x^4+x^3+x+1)
- TIMEOUT, 65535, clk cycles allowed per wait state before abort

Ports:
- clk  in  1  system clock
- rst_n  in  1  one clock; reset is asynchronous and active-low
- clr  in  1  synchronous clear of counters, flags and LFSR (same cycle priority over everything)
- run  in  1  level; enables new frames
- ce  in  1  one-cycle frame request tick (from gennms_1s ceo)
- load  in  1  master frame strobe; low while a frame is in flight, high when idle
- mrx_dat  in  WIDTH  word received by master
- srx_dat  in  WIDTH  word received by slave
- st  out  1  one-cycle start pulse to master
- mtx_dat  out  WIDTH  master transmit word (current LFSR value)
- stx_dat  out  WIDTH  slave transmit word, bitwise inverse of mtx_dat
- pass_cnt  out  16  frames that compared equal, saturating
- fail_cnt  out  16  frames that mismatched or timed out, saturating
- err  out  1  sticky, set on any failure
- tmo  out  1  sticky, set on timeout
- busy  out  1  high in every state except IDLE

## Operation

States and transitions:
- IDLE: on ce=1 and run=1, go to START.
- START: st=1 for exactly one cycle, then go to WAIT_LO.
- WAIT_LO: on load=0, go to WAIT_HI.
- WAIT_HI: on load=1, go to CHECK.
- CHECK: compare and update statistics, then go to ADVANCE.
- ADVANCE: LFSR steps once, then go to IDLE.

Rules:
- LFSR step: next = {cur[WIDTH-2:0], ^(cur & TAPS)}.
- Comparison is performed in CHECK. Pass requires both:
  - mrx_dat == stx_dat
  - srx_dat == mtx_dat
- On pass, pass_cnt increments. On fail, fail_cnt increments and err is set.
- Timeout: a per-state counter is cleared on entry to WAIT_LO and WAIT_HI. When it reaches TIMEOUT:
  - fail_cnt increments; err and tmo are set
  - the LFSR still advances
  - the FSM goes to IDLE via ADVANCE
- Counters saturate at 16'hffff and never wrap.
- ce outside IDLE is ignored and not queued.
- run deasserted mid-frame: the current frame completes normally; no new frame starts.
- clr mid-frame:
  - FSM returns to IDLE
  - counters and flags go to 0
  - LFSR returns to SEED
  - st is forced to 0
- Reset values:
  - FSM: IDLE
  - st, busy, err, tmo: 0
  - pass_cnt, fail_cnt: 0
  - mtx_dat: SEED
  - stx_dat: ~SEED masked to WIDTH

## Timing

- st rises one cycle after the cycle in which ce is sampled high in IDLE; its width is exactly 1 clk.
- mtx_dat/stx_dat are registered and stable from START through CHECK. They change only on the cycle after ADVANCE.
- Comparison uses mrx_dat/srx_dat sampled one cycle after load is seen high in WAIT_HI. This gives the receive registers one cycle to settle.
- Statistics outputs update on the clock edge at the end of CHECK; they are visible 1 cycle after CHECK.
- Minimum frame-to-frame overhead: 4 clk (START, CHECK, ADVANCE, IDLE) beyond the load-low time.
- load low already in START is fine: WAIT_LO exits on the first cycle.
- load glitching high in WAIT_LO is ignored: only the low level is tracked there.

## Structure

- Package spi_pkg holds:
  - WIDTH default
  - state enum (IDLE, START, WAIT_LO, WAIT_HI, CHECK, ADVANCE)
  - default SEED and TAPS constants
- Sub-module lfsr_gen (WIDTH, SEED, TAPS) provides:
  - inputs: clk, rst_n, clr, step
  - output: q
- FSM, timeout counter, comparators and saturating counters live in the top of this block.

## Test plan

- Reset, then run=1 and one ce, with an ideal loopback model (load low 20 cycles):
  - st pulses once
  - mtx_dat=13'h1dad, stx_dat=13'h0252
  - pass_cnt=1, fail_cnt=0
  - mtx_dat becomes 13'h1b5a
- Slave model returns mrx_dat bit 0 flipped: fail_cnt=1, err=1, tmo=0; LFSR still advances to 13'h1b5a.
- load never falls after st: after TIMEOUT cycles, fail_cnt=1, tmo=1, busy=0, mtx_dat=13'h1b5a.
- ce pulses every cycle during a frame: exactly one st per completed frame; pass_cnt equals the frame count.
- clr asserted in WAIT_HI: next cycle busy=0, counters=0, err=0, mtx_dat=13'h1dad; a later ce starts a clean frame.
- Force pass_cnt near saturation (65535 passes, or an abbreviated TIMEOUT/backdoor preload to 16'hfffe): two more passes leave pass_cnt=16'hffff.
